// File: rtl/alu_pkg.sv
// Shared definitions for the serial ALU datapath: op encoding, FSM states and slice-count helper.
package alu_pkg;

    localparam logic ALU_OP_ADD = 1'b0;
    localparam logic ALU_OP_SUB = 1'b1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} alu_state_e;

    function automatic int unsigned alu_slices(input int unsigned width, input int unsigned chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// CHUNK-bit ripple-carry adder built from full adders; also exposes the carry into its top bit.
module chunk_adder #(
    parameter int unsigned CHUNK = 16
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_c_in,
    output logic [CHUNK-1:0] o_sum,
    output logic             o_c_out,
    output logic             o_c_msb_in
);

    logic [CHUNK:0] w_c;

    assign w_c[0] = i_c_in;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
        assign w_c[i+1]  = (i_a[i] & i_b[i]) | (i_a[i] & w_c[i]) | (i_b[i] & w_c[i]);
    end

    assign o_c_out    = w_c[CHUNK];
    assign o_c_msb_in = w_c[CHUNK-1];

endmodule

// File: rtl/alu_serial_addsub.sv
// Multi-cycle add/subtract: one CHUNK-bit slice per clock, LSB slice first, x86-style flags.
module alu_serial_addsub
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CHUNK = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_cf,
    output logic             o_zf,
    output logic             o_sf,
    output logic             o_of
);

    localparam int unsigned N     = alu_slices(WIDTH, CHUNK);
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    if ((WIDTH % CHUNK) != 0 || WIDTH < 2) begin : g_bad_cfg
        $error("alu_serial_addsub: CHUNK must divide WIDTH and WIDTH must be >= 2");
    end

    alu_state_e       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;
    logic             r_op;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_result;
    logic             r_cf;
    logic             r_zf;
    logic             r_sf;
    logic             r_of;

    logic [CHUNK-1:0] w_sum;
    logic             w_cout;
    logic             w_cmsb;
    logic [WIDTH-1:0] w_acc_next;

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .i_a        (r_a[CHUNK-1:0]),
        .i_b        (r_b[CHUNK-1:0]),
        .i_c_in     (r_carry),
        .o_sum      (w_sum),
        .o_c_out    (w_cout),
        .o_c_msb_in (w_cmsb)
    );

    // Operands shift down a slice per cycle; new sum slices enter the accumulator from the top.
    assign w_acc_next = (r_acc >> CHUNK) | (WIDTH'(w_sum) << (WIDTH - CHUNK));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_op     <= ALU_OP_ADD;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_cf     <= 1'b0;
            r_zf     <= 1'b0;
            r_sf     <= 1'b0;
            r_of     <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                        r_a     <= i_a;
                        r_b     <= i_b ^ {WIDTH{i_op}};
                        r_carry <= i_op;
                        r_op    <= i_op;
                        r_idx   <= '0;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> CHUNK;
                    r_b     <= r_b >> CHUNK;
                    r_acc   <= w_acc_next;
                    r_carry <= w_cout;
                    r_idx   <= r_idx + IDX_W'(1);
                    if (r_idx == LAST_IDX) begin
                        r_state  <= DONE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_result <= w_acc_next;
                        r_cf     <= (r_op == ALU_OP_SUB) ? ~w_cout : w_cout;
                        r_zf     <= (w_acc_next == '0);
                        r_sf     <= w_acc_next[WIDTH-1];
                        r_of     <= w_cmsb ^ w_cout;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_result = r_result;
    assign o_cf     = r_cf;
    assign o_zf     = r_zf;
    assign o_sf     = r_sf;
    assign o_of     = r_of;

endmodule

// File: tb/tb_alu_serial_addsub.sv
// Directed bench: 4-slice instance (64/16) and single-slice instance (64/64) sharing clock and reset.
module tb_alu_serial_addsub;
    import alu_pkg::*;

    typedef struct {
        string       name;
        logic        op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic [3:0]  fl;   // {cf, zf, sf, of}
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st0 = 1'b0;
    logic        st1 = 1'b0;
    logic        op = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    int          sel = 0;

    logic        busy0, done0, cf0, zf0, sf0, of0;
    logic        busy1, done1, cf1, zf1, sf1, of1;
    logic [63:0] res0, res1;

    logic        m_busy, m_done;
    logic [63:0] m_res;
    logic [3:0]  m_fl;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_serial_addsub #(.WIDTH(64), .CHUNK(16)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(st0), .i_op(op), .i_a(a), .i_b(b),
        .o_busy(busy0), .o_done(done0), .o_result(res0),
        .o_cf(cf0), .o_zf(zf0), .o_sf(sf0), .o_of(of0)
    );

    alu_serial_addsub #(.WIDTH(64), .CHUNK(64)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(st1), .i_op(op), .i_a(a), .i_b(b),
        .o_busy(busy1), .o_done(done1), .o_result(res1),
        .o_cf(cf1), .o_zf(zf1), .o_sf(sf1), .o_of(of1)
    );

    always_comb begin
        m_busy = (sel == 1) ? busy1 : busy0;
        m_done = (sel == 1) ? done1 : done0;
        m_res  = (sel == 1) ? res1 : res0;
        m_fl   = (sel == 1) ? {cf1, zf1, sf1, of1} : {cf0, zf0, sf0, of0};
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one op on instance s; lat = edges after the sampling edge until done is seen.
    task automatic do_op(input int s, input logic o, input logic [63:0] xa, input logic [63:0] xb,
                         output logic [63:0] r, output logic [3:0] f, output int lat);
        sel = s;
        @(posedge clk); #1;
        st0 = (s == 0); st1 = (s == 1); op = o; a = xa; b = xb;
        @(posedge clk); #1;
        st0 = 1'b0; st1 = 1'b0;
        check("busy_after_start", 64'(m_busy), 64'd1);
        lat = 0;
        while (m_done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        r = m_res;
        f = m_fl;
    endtask

    vec_t        vecs[10];
    logic [63:0] r;
    logic [3:0]  f;
    int          lat;
    int          cnt;
    logic        seen;

    initial begin
        vecs[0] = '{"add_wrap",   ALU_OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
                    64'h0, 4'b1100};
        vecs[1] = '{"add_slice_carry", ALU_OP_ADD, 64'h0000_0000_0000_FFFF, 64'd1,
                    64'h0000_0000_0001_0000, 4'b0000};
        vecs[2] = '{"sub_borrow", ALU_OP_SUB, 64'd5, 64'd7,
                    64'hFFFF_FFFF_FFFF_FFFE, 4'b1010};
        vecs[3] = '{"sub_ovf",    ALU_OP_SUB, 64'h8000_0000_0000_0000, 64'd1,
                    64'h7FFF_FFFF_FFFF_FFFF, 4'b0001};
        vecs[4] = '{"add_ovf",    ALU_OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
                    64'h8000_0000_0000_0000, 4'b0011};
        vecs[5] = '{"sub_0_1",    ALU_OP_SUB, 64'd0, 64'd1,
                    64'hFFFF_FFFF_FFFF_FFFF, 4'b1010};
        vecs[6] = '{"sub_7_5",    ALU_OP_SUB, 64'd7, 64'd5, 64'd2, 4'b0000};
        vecs[7] = '{"add_ripple", ALU_OP_ADD, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321,
                    64'h2222_2222_2222_2211, 4'b0000};
        vecs[8] = '{"sub_equal",  ALU_OP_SUB, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                    64'h0, 4'b0100};
        vecs[9] = '{"add_min_min", ALU_OP_ADD, 64'h8000_0000_0000_0000,
                    64'h8000_0000_0000_0000, 64'h0, 4'b1101};

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'({busy0, busy1}), 64'd0);
        check("rst_done", 64'({done0, done1}), 64'd0);
        check("rst_result", res0 | res1, 64'd0);
        check("rst_flags", 64'({cf0, zf0, sf0, of0, cf1, zf1, sf1, of1}), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            do_op(0, vecs[i].op, vecs[i].a, vecs[i].b, r, f, lat);
            check({vecs[i].name, "_lat"}, 64'(lat), 64'd4);
            check({vecs[i].name, "_res"}, r, vecs[i].res);
            check({vecs[i].name, "_flags"}, 64'(f), 64'(vecs[i].fl));
        end

        // start during RUN with different operands must be ignored
        sel = 0;
        @(posedge clk); #1;
        st0 = 1'b1; op = ALU_OP_ADD; a = 64'd1; b = 64'd2;
        @(posedge clk); #1;
        st0 = 1'b0;
        @(posedge clk); #1;
        st0 = 1'b1; op = ALU_OP_SUB; a = 64'd100; b = 64'd1;
        @(posedge clk); #1;
        st0 = 1'b0;
        cnt = 2;
        while (done0 !== 1'b1 && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("ignore_lat", 64'(cnt), 64'd4);
        check("ignore_res", res0, 64'd3);

        // back-to-back: start in the done cycle
        do_op(0, ALU_OP_ADD, 64'd10, 64'd20, r, f, lat);
        check("b2b_first_res", r, 64'd30);
        st0 = 1'b1; op = ALU_OP_SUB; a = 64'd50; b = 64'd8;
        @(posedge clk); #1;
        st0 = 1'b0;
        check("b2b_done_one_cycle", 64'(done0), 64'd0);
        cnt = 1;
        while (done0 !== 1'b1 && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("b2b_gap", 64'(cnt), 64'd5);
        check("b2b_second_res", res0, 64'd42);
        @(posedge clk); #1;
        check("b2b_done_drop", 64'(done0), 64'd0);

        // reset at slice 2 discards the op
        @(posedge clk); #1;
        st0 = 1'b1; op = ALU_OP_ADD; a = 64'd7; b = 64'd9;
        @(posedge clk); #1;
        st0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_busy_done", 64'({busy0, done0}), 64'd0);
        check("midrst_result", res0, 64'd0);
        check("midrst_flags", 64'({cf0, zf0, sf0, of0}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done0 === 1'b1 || busy0 === 1'b1) seen = 1'b1;
        end
        check("midrst_no_done", 64'(seen), 64'd0);
        do_op(0, ALU_OP_ADD, 64'hFFFF, 64'd1, r, f, lat);
        check("post_rst_lat", 64'(lat), 64'd4);
        check("post_rst_res", r, 64'h1_0000);

        // single-slice mode
        do_op(1, ALU_OP_SUB, 64'd3, 64'd3, r, f, lat);
        check("ss_sub_lat", 64'(lat), 64'd1);
        check("ss_sub_res", r, 64'd0);
        check("ss_sub_flags", 64'(f), 64'(4'b0100));
        do_op(1, ALU_OP_SUB, 64'h8000_0000_0000_0000, 64'd1, r, f, lat);
        check("ss_ovf_res", r, 64'h7FFF_FFFF_FFFF_FFFF);
        check("ss_ovf_flags", 64'(f), 64'(4'b0001));
        do_op(1, ALU_OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, r, f, lat);
        check("ss_wrap_flags", 64'(f), 64'(4'b1100));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_serial_addsub.md
# alu_serial_addsub

Multi-cycle, parametrised add/subtract unit for the SEQ ALU datapath. It processes a WIDTH-bit operation in CHUNK-bit slices, least-significant slice first, using one CHUNK-bit adder per clock. It produces the result plus x86-style condition flags (CF, ZF, SF, OF) and uses a start/done handshake. It trades latency for adder area and supports both ADD and SUB, with borrow semantics on SUB.

## Interface
- WIDTH, 64, operand/result width in bits; ≥ 2.
- CHUNK, 16, bits processed per cycle; must divide WIDTH; CHUNK = WIDTH is legal (single-slice mode).
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only when busy = 0.
- op  in  1  0 = ADD (a + b), 1 = SUB (a − b); sampled with start.
- a  in  WIDTH  operand A; sampled with start.
- b  in  WIDTH  operand B; sampled with start.
- busy  out  1  high while slices are being computed.
- done  out  1  one-cycle pulse; result and flags are valid from this cycle.
- result  out  WIDTH  sum/difference; held until the next completion.
- cf  out  1  ADD: carry-out. SUB: borrow, i.e. NOT carry-out.
- zf  out  1  result == 0.
- sf  out  1  result[WIDTH−1].
- of  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- N = WIDTH/CHUNK slices.
- FSM states:
  - IDLE: busy = 0, done = 0.
  - RUN: busy = 1.
  - DONE: busy = 0, done = 1.
- IDLE + start → RUN. The block latches a, b XOR {WIDTH{op}}, and carry = op; slice index = 0.
- RUN: each cycle adds slice[idx] of A and B' with the carry register and writes the slice into an internal accumulator.
  - The carry register takes the slice carry-out. Carry into the top bit is captured on the last slice.
  - idx increments; after slice N−1 → DONE.
- On the RUN → DONE edge, result, cf, zf, sf and of are loaded from the accumulator and carries in the same update.
- Outside that edge, result and flags do not change; the accumulator is internal only.
- DONE → IDLE, or DONE + start → RUN. Back-to-back operation is allowed; done still pulses exactly one cycle.
- start while busy = 1 is ignored; no queuing. op, a and b are don't-care except when start is accepted.
- Arithmetic is modulo 2^WIDTH; there is no saturation.

## Timing
- Reset (rst_n low, any state, including mid-RUN): immediately forces IDLE.
  - busy = 0, done = 0, result = 0, cf = zf = sf = of = 0.
  - The operation in progress is discarded, with no done pulse.
- Reset release: first start is accepted on the first rising edge with rst_n high.
- Latency: start is sampled on edge E. busy = 1 after E through edge E+N. done = 1 for the cycle after edge E+N.
- Throughput: one operation per N+1 cycles. A start asserted in the DONE cycle begins RUN at the next edge.
- CHUNK = WIDTH: N = 1, so done is high two cycles after start is sampled.

## Structure
- Shared package alu_pkg:
  - Op encoding constants ALU_OP_ADD = 1'b0 and ALU_OP_SUB = 1'b1.
  - FSM state typedef {IDLE, RUN, DONE}.
  - Slice-count helper function WIDTH/CHUNK.
- One sub-module, chunk_adder: CHUNK-bit ripple adder built from full adders.
  - Inputs: a, b, c_in. Outputs: sum, c_out, and c_msb_in (carry into its top bit), used for OF.
- Elaboration-time check: WIDTH % CHUNK == 0; otherwise stop with an error.

## Test plan
- **ADD wrap:** WIDTH=64, CHUNK=16, ADD a=64'hFFFF_FFFF_FFFF_FFFF, b=1.
  - Expect: done 5 cycles after start sampled; result=0, cf=1, zf=1, sf=0, of=0.
- **Inter-slice carry:** ADD a=64'h0000_0000_0000_FFFF, b=1.
  - Expect: result=64'h0000_0000_0001_0000, all flags 0.
- **SUB borrow:** SUB a=5, b=7.
  - Expect: result=64'hFFFF_FFFF_FFFF_FFFE, cf=1, sf=1, zf=0, of=0.
- **SUB overflow:** SUB a=64'h8000_0000_0000_0000, b=1.
  - Expect: result=64'h7FFF_FFFF_FFFF_FFFF, of=1, cf=0, sf=0.
- **Handshake:**
  - start asserted during RUN with different operands: ignored, and the original result is returned.
  - start during the done cycle: the second done follows exactly 5 cycles later.
  - rst_n pulsed low at slice 2: no done pulse; all outputs read 0.
- **Single-slice mode:** CHUNK=64, SUB a=3, b=3.
  - Expect: done 2 cycles after start sampled; result=0, zf=1, cf=0.
